seq_det_p: RTL and testbench

SEQ_DET_P -- requirements
Module: seq_det_p

---
 rtl/seq_det_pkg.sv | 52 +++++
 rtl/seq_det_sat_cnt.sv | 30 +++
 rtl/seq_det_p.sv | 87 ++++++++
 tb/tb_seq_det_p.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time KMP table builders for the serial pattern detector.
// Tables are packed so they can be held in localparams and indexed directly by the FSM state.
package seq_det_pkg;

  localparam int MAX_PAT_W = 16;
  localparam int DEF_PAT_W = 4;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1011;

  // One 5-bit length entry per prefix length / state, enough to hold values 0..16
  typedef logic [MAX_PAT_W-1:0][4:0] kmp_tbl_t;

  // Bit j of the pattern in arrival order (j = 0 is the first bit received)
  function automatic logic pat_bit(input logic [MAX_PAT_W-1:0] pat, input int w, input int j);
    logic [MAX_PAT_W-1:0] s;
    s = pat >> (w - 1 - j);
    return s[0];
  endfunction

  function automatic kmp_tbl_t border_table(input logic [MAX_PAT_W-1:0] pat, input int w);
    kmp_tbl_t brd;
    int k;
    brd = '0;
    k = 0;
    for (int i = 1; i < MAX_PAT_W; i++) begin
      if (i < w) begin
        while (k > 0 && pat_bit(pat, w, i) != pat_bit(pat, w, k)) k = int'(brd[4'(k - 1)]);
        if (pat_bit(pat, w, i) == pat_bit(pat, w, k)) k++;
        brd[4'(i)] = 5'(k);
      end
    end
    return brd;
  endfunction

  // Next matched-prefix length from each state when bit b arrives; value w means a full match
  function automatic kmp_tbl_t next_table(input logic [MAX_PAT_W-1:0] pat, input int w, input logic b);
    kmp_tbl_t brd;
    kmp_tbl_t nxt;
    int j;
    brd = border_table(pat, w);
    nxt = '0;
    for (int k = 0; k < MAX_PAT_W; k++) begin
      if (k < w) begin
        j = k;
        while (j > 0 && pat_bit(pat, w, j) != b) j = int'(brd[4'(j - 1)]);
        if (pat_bit(pat, w, j) == b) j++;
        nxt[4'(k)] = 5'(j);
      end
    end
    return nxt;
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating match counter; clr and rst both zero it, and it never wraps past all ones.
module seq_det_sat_cnt
  import seq_det_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (inc && !sat) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    cnt = r_cnt;
    sat = &r_cnt;
  end

endmodule

// File: rtl/seq_det_p.sv
// Serial pattern detector with KMP progress FSM, registered match pulse and optional counter.
// Define SEQ_DET_CNT_EN to include the saturating match counter; otherwise match_cnt/cnt_sat are 0.
module seq_det_p
  import seq_det_pkg::*;
#(
  parameter int                 PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0]   PATTERN = PAT_W'(DEF_PATTERN),
  parameter int                 OVERLAP = 1,
  parameter int                 CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       x,
  input  logic                       x_valid,
  input  logic                       clear,
  output logic                       y,
  output logic [$clog2(PAT_W+1)-1:0] prog,
  output logic [CNT_W-1:0]           match_cnt,
  output logic                       cnt_sat
);

  localparam int PW = $clog2(PAT_W + 1);

  if (PAT_W < 2 || PAT_W > MAX_PAT_W) begin : g_badWidth
    $error("seq_det_p: PAT_W must be in 2..16");
  end

  localparam kmp_tbl_t NXT0 = next_table(MAX_PAT_W'(PATTERN), PAT_W, 1'b0);
  localparam kmp_tbl_t NXT1 = next_table(MAX_PAT_W'(PATTERN), PAT_W, 1'b1);
  localparam kmp_tbl_t BRD  = border_table(MAX_PAT_W'(PATTERN), PAT_W);
  localparam int       BORDER = int'(BRD[PAT_W-1]);

  logic [PW-1:0] r_state;
  logic          r_y;
  logic [PW-1:0] w_nextState;
  logic          w_hit;
  logic [3:0]    w_idx;
  logic [4:0]    w_cand;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state <= '0;
      r_y     <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_y     <= w_hit;
    end
  end

  // A completed pattern never becomes a state: it restarts from the border (or P0)
  always_comb begin
    w_idx       = 4'(r_state);
    w_cand      = x ? NXT1[w_idx] : NXT0[w_idx];
    w_nextState = r_state;
    w_hit       = 1'b0;
    if (x_valid) begin
      if (w_cand == 5'(PAT_W)) begin
        w_hit       = 1'b1;
        w_nextState = (OVERLAP != 0) ? PW'(BORDER) : '0;
      end else begin
        w_nextState = PW'(w_cand);
      end
    end
  end

  always_comb begin
    y    = r_y;
    prog = r_state;
  end

`ifdef SEQ_DET_CNT_EN
  seq_det_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(clear),
    .inc(w_hit),
    .cnt(match_cnt),
    .sat(cnt_sat)
  );
`else
  assign match_cnt = '0;
  assign cnt_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_det_p.sv
// Randomized self-checking bench for seq_det_p: three instances (overlap, no-overlap, 2-bit counter)
// compared every cycle against a history-based model that searches suffixes of the accepted bits.
module tb_seq_det_p;

  localparam int PW = 4;
  localparam logic [PW-1:0] PAT = 4'b1011;

  logic clk = 1'b0;
  logic rst, x, x_valid, clear;

  logic       yA, yB, yC;
  logic [2:0] progA, progB, progC;
  logic [7:0] cntA, cntB;
  logic [1:0] cntC;
  logic       satA, satB, satC;

  int checks = 0;
  int errors = 0;

  // Model state per instance: accepted-bit history since the last restart point
  int unsigned hist[3];
  int          len[3];
  int          expY[3];
  int          expCnt[3];
  int          ov[3]   = '{1, 0, 1};
  int          cmax[3] = '{255, 255, 3};

  always #5 clk = ~clk;

  seq_det_p uA (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .clear(clear),
    .y(yA), .prog(progA), .match_cnt(cntA), .cnt_sat(satA)
  );

  seq_det_p #(.OVERLAP(0)) uB (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .clear(clear),
    .y(yB), .prog(progB), .match_cnt(cntB), .cnt_sat(satB)
  );

  seq_det_p #(.CNT_W(2)) uC (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .clear(clear),
    .y(yC), .prog(progC), .match_cnt(cntC), .cnt_sat(satC)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int lowBits(input int unsigned v, input int k);
    return int'(v & ((32'd1 << k) - 1));
  endfunction

  // Longest k < PW such that the last k accepted bits equal the first k pattern bits
  function automatic int modelProg(input int i);
    for (int k = PW - 1; k >= 1; k--) begin
      if (len[i] >= k && lowBits(hist[i], k) == int'(PAT >> (PW - k))) return k;
    end
    return 0;
  endfunction

  function automatic int modelCnt(input int i);
`ifdef SEQ_DET_CNT_EN
    return expCnt[i];
`else
    return 0 * i;
`endif
  endfunction

  function automatic int modelSat(input int i);
`ifdef SEQ_DET_CNT_EN
    return (expCnt[i] == cmax[i]) ? 1 : 0;
`else
    return 0 * i;
`endif
  endfunction

  function automatic void modelStep(input logic r, input logic c, input logic v, input logic b);
    for (int i = 0; i < 3; i++) begin
      expY[i] = 0;
      if (r || c) begin
        hist[i]   = 0;
        len[i]    = 0;
        expCnt[i] = 0;
      end else if (v) begin
        hist[i] = (hist[i] << 1) | int'(b);
        len[i]  = (len[i] < 16) ? len[i] + 1 : 16;
        if (len[i] >= PW && lowBits(hist[i], PW) == int'(PAT)) begin
          expY[i]   = 1;
          expCnt[i] = (expCnt[i] < cmax[i]) ? expCnt[i] + 1 : cmax[i];
          if (ov[i] == 0) len[i] = 0;
        end
      end
    end
  endfunction

  task automatic applyStimulus(input logic r, input logic c, input logic v, input logic b);
    rst = r; clear = c; x_valid = v; x = b;
    @(posedge clk);
    modelStep(r, c, v, b);
    #1;
    checkOutput("A.y",    int'(yA),    expY[0]);
    checkOutput("A.prog", int'(progA), modelProg(0));
    checkOutput("A.cnt",  int'(cntA),  modelCnt(0));
    checkOutput("A.sat",  int'(satA),  modelSat(0));
    checkOutput("B.y",    int'(yB),    expY[1]);
    checkOutput("B.prog", int'(progB), modelProg(1));
    checkOutput("B.cnt",  int'(cntB),  modelCnt(1));
    checkOutput("B.sat",  int'(satB),  modelSat(1));
    checkOutput("C.y",    int'(yC),    expY[2]);
    checkOutput("C.prog", int'(progC), modelProg(2));
    checkOutput("C.cnt",  int'(cntC),  modelCnt(2));
    checkOutput("C.sat",  int'(satC),  modelSat(2));
  endtask

  task automatic sendBits(input logic [15:0] bits, input int n);
    logic [15:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) applyStimulus(1'b0, 1'b0, 1'b1, v[i]);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; x_valid = 1'b0; x = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hist[i] = 0; len[i] = 0; expY[i] = 0; expCnt[i] = 0;
    end

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);

    $display("[TB] single match 1011");
    sendBits(16'b1011, 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] overlapping stream 1011011");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    sendBits(16'b1011011, 7);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] gap in x_valid");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    sendBits(16'b10, 2);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    sendBits(16'b11, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] clear beats x_valid");
    sendBits(16'b101, 3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] saturation with five matches");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int m = 0; m < 5; m++) sendBits(16'b1011, 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    sendBits(16'b101, 3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] random stream");
    for (int n = 0; n < 800; n++) begin
      applyStimulus(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                    1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
